// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (iA - iB - iBorrowIn) mod 2^WIDTH one bit
// per clock, LSB first, through a single full-subtractor cell. A start/busy/
// done handshake wraps the operand shifters, borrow register and bit counter.

// One-bit full subtractor cell: iA - iB - iC.
module mFullSubtractor (
  input  logic iA,
  input  logic iB,
  input  logic iC,
  output logic oDiff,
  output logic oBorrow
);
  assign oDiff   = iA ^ iB ^ iC;
  assign oBorrow = (~iA & (iB | iC)) | (iB & iC);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iBorrowIn,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oDiff,
  output logic             oBorrow,
  output logic             oZero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             brw_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;
  logic             cell_diff;
  logic             cell_brw;
  logic             last_bit;

  mFullSubtractor u_cell (
    .iA      (sa_q[0]),
    .iB      (sb_q[0]),
    .iC      (brw_q),
    .oDiff   (cell_diff),
    .oBorrow (cell_brw)
  );

  // Next accumulator value: the new difference bit enters at the MSB so that
  // after WIDTH shifts the first (LSB) bit has reached position 0.
  always_comb begin
    acc_d    = {cell_diff, acc_q[WIDTH-1:1]};
    last_bit = (cnt_q == LAST_CNT);
  end

  // Control FSM with datapath; results only change on the final RUN cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      acc_q    <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (iStart) begin
            sa_q    <= iA;
            sb_q    <= iB;
            brw_q   <= iBorrowIn;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          acc_q <= acc_d;
          brw_q <= cell_brw;
          if (last_bit) begin
            diff_q   <= acc_d;
            borrow_q <= cell_brw;
            zero_q   <= (acc_d == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            // Held at WIDTH-1 on the last cycle so it never wraps mid-run.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oDiff   = diff_q;
  assign oBorrow = borrow_q;
  assign oZero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done, brw, zero;
  logic [7:0] diff;

  logic        start16;
  logic [15:0] a16, b16;
  logic        bin16;
  logic        busy16, done16, brw16, zero16;
  logic [15:0] diff16;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iA(a), .iB(b),
    .iBorrowIn(bin), .oBusy(busy), .oDone(done), .oDiff(diff),
    .oBorrow(brw), .oZero(zero)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start16), .iA(a16), .iB(b16),
    .iBorrowIn(bin16), .oBusy(busy16), .oDone(done16), .oDiff(diff16),
    .oBorrow(brw16), .oZero(zero16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       brw;
    logic       zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // One WIDTH=8 operation. Edges are counted from the accept edge (edge 0).
  // When inject >= 0 a spurious iStart with other operands is pulsed after
  // RUN edge 'inject'. prof_ok records that oBusy stayed high and oDiff held
  // its previous value throughout RUN, and that oBusy dropped with oDone.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                      input int inject, output int edges, output logic prof_ok);
    logic [7:0] prev;
    prev = diff;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    prof_ok = 1'b1;
    while (done !== 1'b1 && edges < 40) begin
      if (busy !== 1'b1 || diff !== prev) prof_ok = 1'b0;
      if (edges == inject) begin
        start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    if (busy !== 1'b0) prof_ok = 1'b0;
  endtask

  task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                       output int edges);
    @(negedge clk);
    a16 = ia; b16 = ib; bin16 = ibin; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    edges = 0;
    while (done16 !== 1'b1 && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int         e, e1, e2;
    logic       ok, saw_done, saw_busy;
    logic [8:0] m8;
    logic [16:0] m16;
    logic [7:0] ra, rb;
    logic [15:0] ra16, rb16;
    logic       rbin;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_diff", {24'b0, diff}, 32'd0);
    check("reset_borrow", {31'b0, brw}, 32'd0);
    check("reset_zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].bin, -1, e, ok);
      check($sformatf("vec%0d_diff", i), {24'b0, diff}, {24'b0, vecs[i].diff});
      check($sformatf("vec%0d_borrow", i), {31'b0, brw}, {31'b0, vecs[i].brw});
      check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].zero});
      check($sformatf("vec%0d_latency", i), e, 32'd8);
      check($sformatf("vec%0d_busy_hold", i), {31'b0, ok}, 32'd1);
    end

    // iStart pulsed 3 cycles into RUN must be ignored
    run8(8'h35, 8'h12, 1'b0, 3, e, ok);
    check("ignore_diff", {24'b0, diff}, 32'h23);
    check("ignore_borrow", {31'b0, brw}, 32'd0);
    check("ignore_latency", e, 32'd8);
    check("ignore_busy_hold", {31'b0, ok}, 32'd1);
    // the done cycle must not start another run
    @(posedge clk); #1;
    check("ignore_no_rerun", {31'b0, busy}, 32'd0);

    // Back-to-back: iStart held high, operands changed after each accept
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20; bin = 1'b1;
    e = 0;
    while (done !== 1'b1 && e < 40) begin
      @(posedge clk); #1; e++;
    end
    e1 = e;
    check("b2b_first_diff", {24'b0, diff}, 32'h23);
    check("b2b_first_borrow", {31'b0, brw}, 32'd0);
    @(posedge clk); #1; e++;
    start = 1'b0;
    check("b2b_reaccept_busy", {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && e < 80) begin
      @(posedge clk); #1; e++;
    end
    e2 = e;
    check("b2b_first_latency", e1, 32'd8);
    check("b2b_spacing", e2 - e1, 32'd9);
    check("b2b_second_diff", {24'b0, diff}, 32'hEF);
    check("b2b_second_borrow", {31'b0, brw}, 32'd1);

    // Reset asserted in RUN cycle 4 aborts the operation asynchronously
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_diff", {24'b0, diff}, 32'd0);
    check("abort_borrow", {31'b0, brw}, 32'd0);
    check("abort_zero", {31'b0, zero}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0; saw_busy = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);
    check("abort_stays_idle", {31'b0, saw_busy}, 32'd0);
    run8(8'h35, 8'h12, 1'b0, -1, e, ok);
    check("abort_restart_diff", {24'b0, diff}, 32'h23);
    check("abort_restart_latency", e, 32'd8);

    // Random regression, WIDTH=8
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      m8 = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
      run8(ra, rb, rbin, -1, e, ok);
      check("rand8", {22'b0, e[1:0] == 2'd0 && e == 8, zero, brw, diff},
            {22'b0, 1'b1, m8[7:0] == 8'h00, m8[8], m8[7:0]});
    end

    // WIDTH=16: corner then random regression
    run16(16'h0000, 16'h0001, 1'b0, e);
    check("w16_corner", {15'b0, zero16, brw16, diff16}, {15'b0, 1'b0, 1'b1, 16'hFFFF});
    check("w16_latency", e, 32'd16);
    for (int i = 0; i < 100; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rbin = 1'($urandom);
      m16 = {1'b0, ra16} - {1'b0, rb16} - {16'b0, rbin};
      run16(ra16, rb16, rbin, e);
      check("rand16", {13'b0, e == 16, zero16, brw16, diff16},
            {13'b0, 1'b1, m16[15:0] == 16'h0000, m16[16], m16[15:0]});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
